spi_master: RTL
===============

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter SSN_LEAD, default 2: clk cycles from ssn falling to the first sck edge.
REQ-002 SHALL have parameter SSN_LAG, default 2: clk cycles from the 16th sck edge to ssn rising.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on posedge clk.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port data, input, 8: byte to transmit, sampled at start.
REQ-006 SHALL have port spcon, input, 8: [2]=cpol, [1]=cpha, sampled at start; other bits ignored.
REQ-007 SHALL have port spibr, input, 8: sck half-period select, sampled at start.
REQ-008 SHALL have port start, input, 1: transfer request, one-cycle pulse or level.
REQ-009 SHALL have port miso, input, 1: serial data from the slave.
REQ-010 SHALL have ports sck, mosi, ssn, output, 1 each: SPI clock, master data out, and active-low slave select.
REQ-011 SHALL have port rx_data, output, 8: last received byte.
REQ-012 SHALL have port busy, output, 1: high from start acceptance until done.
REQ-013 SHALL have port done, output, 1: one-cycle pulse at transfer end.

Function
REQ-014 SHALL implement the states IDLE, LEAD, XFER, LAG and DONE.
REQ-015 IDLE: start=1 SHALL latch data, cpol, cpha and the divisor, then move to LEAD next cycle with busy=1 and ssn=0.
REQ-016 start while busy=1 SHALL be ignored, with no queuing.
REQ-017 In IDLE, sck SHALL follow spcon[2]; ssn=1.
REQ-018 Divisor: sck half-period = (max(spibr,3)+1) clk cycles. spibr<3 SHALL be clamped to 3 so the slave's two-flop sck sampling sees every edge.
REQ-019 LEAD SHALL last SSN_LEAD cycles. In LEAD with cpha=0, mosi SHALL already carry data[7].
REQ-020 XFER SHALL generate exactly 16 sck edges, numbered 1..16. The first edge is a transition away from cpol.
REQ-021 With cpha=0, odd edges SHALL sample miso into the rx shift register, MSB first. Even edges 2..14 SHALL drive the next tx bit on mosi.
REQ-022 With cpha=1, odd edges SHALL drive the tx bit on mosi, MSB first. Even edges SHALL sample miso.
REQ-023 After edge 16, sck SHALL equal cpol and the FSM SHALL enter LAG for SSN_LAG cycles.
REQ-024 In LAG, ssn SHALL remain 0. On LAG exit, ssn=1 and the FSM enters DONE.
REQ-025 DONE SHALL last one cycle with done=1, rx_data updated with the full received byte, and busy=0 on the following cycle. Return to IDLE.
REQ-026 rx_data SHALL hold its value until the next DONE.
REQ-027 Changes to data, spcon or spibr during busy SHALL have no effect on the current transfer.
REQ-028 start asserted in the DONE cycle SHALL be ignored. It is accepted in IDLE one cycle later.
REQ-029 The divider counter SHALL reload at every edge and wrap with no drift. There SHALL be no missing or extra edges at any divisor value 0..255.

Reset
REQ-030 rst_n=0 at a clk edge SHALL force IDLE. Outputs: ssn=1, sck=0, mosi=0, busy=0, done=0, rx_data=8'h00. Divider, edge counter and shift registers SHALL clear.
REQ-031 Reset asserted mid-transfer SHALL abort it immediately: ssn rises at that edge, with no done pulse and rx_data set to 0.

Configuration
REQ-032 Macro SPI_MASTER_IRQ_EN defined: SHALL add input irq_clr and output irq. irq is set at DONE, held until irq_clr=1, and reset to 0. If DONE and irq_clr coincide, set wins.
REQ-033 Macro SPI_MASTER_IRQ_EN undefined: irq and irq_clr SHALL be absent; all other behaviour is identical.

Verification
REQ-034 Mode 0 (cpol=0, cpha=0), spibr=3, data=8'hA5, slave returns 8'h3C: 16 edges, half-period 4 clk, mosi bits 1,0,1,0,0,1,0,1, rx_data=8'h3C at done.
REQ-035 Modes 1, 2 and 3 with data=8'h81 against the spi_slave model loaded with 8'h7E: master rx_data=8'h7E and slave received byte 8'h81 in each mode.
REQ-036 spibr=0 vs spibr=3: identical waveforms, half-period 4 clk. spibr=255: half-period 256 clk, 16 edges counted.
REQ-037 start re-pulsed mid-XFER, and data changed to 8'hFF mid-XFER: the original byte completes, a single done pulse occurs, no second transfer.
REQ-038 rst_n=0 at edge 7 of a transfer: the next cycle shows ssn=1, sck=0, busy=0, no done; a following start completes normally.
REQ-039 With SPI_MASTER_IRQ_EN: irq rises at done, stays high, clears one cycle after irq_clr=1. irq_clr coincident with done leaves irq=1.

Source files
------------

// File: rtl/spi_master.sv
// spi_master: single-byte SPI master with CPOL/CPHA, clamped sck divider and ssn lead/lag timing.
// Defining SPI_MASTER_IRQ_EN adds a sticky irq output with an irq_clr input.
module spi_master #(
    parameter int SSN_LEAD = 2,
    parameter int SSN_LAG  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic [7:0] spcon,
    input  logic [7:0] spibr,
    input  logic       start,
    input  logic       miso,
    output logic       sck,
    output logic       mosi,
    output logic       ssn,
    output logic [7:0] rx_data,
    output logic       busy,
`ifdef SPI_MASTER_IRQ_EN
    input  logic       irq_clr,
    output logic       irq,
`endif
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEAD = 3'd1,
        XFER = 3'd2,
        LAG  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t      state_r;
    logic [15:0] tmr_r;
    logic [4:0]  ecnt_r;
    logic [7:0]  div_r;
    logic [7:0]  tx_r;
    logic [7:0]  rx_r;
    logic        cpol_r;
    logic        cpha_r;

    logic        tick_s;
    logic        samp_s;
    logic        drv_s;
    logic        last_s;
    logic [4:0]  edge_num_s;
    logic [7:0]  div_s;
    logic        unused_s;

    assign unused_s = ^{spcon[7:3], spcon[0]};

    // Edge timing decode: which sck edge fires this cycle and what it does.
    always_comb begin
        div_s      = (spibr < 8'd3) ? 8'd3 : spibr;
        edge_num_s = ecnt_r + 5'd1;
        if (((state_r == LEAD) || (state_r == XFER)) && (tmr_r == 16'd0)) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
        // odd edges sample when cpha=0, even edges sample when cpha=1
        samp_s = tick_s && (edge_num_s[0] != cpha_r);
        drv_s  = tick_s && (edge_num_s[0] == cpha_r) && (edge_num_s != 5'd16);
        last_s = tick_s && (edge_num_s == 5'd16);
    end

    // Transfer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            tmr_r   <= 16'd0;
            ecnt_r  <= 5'd0;
            div_r   <= 8'd0;
            tx_r    <= 8'd0;
            rx_r    <= 8'd0;
            cpol_r  <= 1'b0;
            cpha_r  <= 1'b0;
            sck     <= 1'b0;
            mosi    <= 1'b0;
            ssn     <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            rx_data <= 8'h00;
`ifdef SPI_MASTER_IRQ_EN
            irq     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    sck <= spcon[2];
                    if (start) begin
                        state_r <= LEAD;
                        busy    <= 1'b1;
                        ssn     <= 1'b0;
                        tx_r    <= data;
                        rx_r    <= 8'd0;
                        cpol_r  <= spcon[2];
                        cpha_r  <= spcon[1];
                        div_r   <= div_s;
                        tmr_r   <= 16'(SSN_LEAD - 1);
                        ecnt_r  <= 5'd0;
                        mosi    <= spcon[1] ? 1'b0 : data[7];
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LEAD, XFER: begin
                    if (tick_s) begin
                        sck    <= ~sck;
                        ecnt_r <= edge_num_s;
                        if (samp_s) begin
                            rx_r <= {rx_r[6:0], miso};
                        end
                        if (drv_s) begin
                            // cpha=0 already shows bit 7, so it advances to the next bit
                            mosi <= cpha_r ? tx_r[7] : tx_r[6];
                            tx_r <= {tx_r[6:0], 1'b0};
                        end
                        if (last_s) begin
                            state_r <= LAG;
                            tmr_r   <= 16'(SSN_LAG - 1);
                        end else begin
                            state_r <= XFER;
                            tmr_r   <= {8'd0, div_r};
                        end
                    end else begin
                        tmr_r <= tmr_r - 16'd1;
                    end
                end
                LAG: begin
                    if (tmr_r == 16'd0) begin
                        state_r <= DONE;
                        ssn     <= 1'b1;
                        done    <= 1'b1;
                        rx_data <= rx_r;
                    end else begin
                        tmr_r <= tmr_r - 16'd1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    ssn     <= 1'b1;
                end
            endcase
`ifdef SPI_MASTER_IRQ_EN
            // set (entering or sitting in DONE) dominates clear
            if (((state_r == LAG) && (tmr_r == 16'd0)) || (state_r == DONE)) begin
                irq <= 1'b1;
            end else if (irq_clr) begin
                irq <= 1'b0;
            end else begin
                irq <= irq;
            end
`endif
        end
    end

endmodule
